// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the stack machine's I/O bus.
// The CPU pushes bytes into a small FIFO; a serializer FSM shifts them out LSB first.
module io_uart_tx #(
  parameter int unsigned          CPU_WIDTH    = 16,
  parameter logic [CPU_WIDTH-1:0] BASE_ADDR    = 16'h4000,
  parameter int unsigned          CLKS_PER_BIT = 217,
  parameter int unsigned          FIFO_DEPTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CPU_WIDTH-1:0] io_addr,
  input  logic                 io_write,
  input  logic [CPU_WIDTH-1:0] io_wr_data,
  output logic [CPU_WIDTH-1:0] io_rd_data,
  output logic                 io_sel,
  output logic                 tx,
  output logic                 tx_active
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BCNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [BCNT_W-1:0] BCNT_RELOAD = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  typedef enum logic [1:0] {
    REG_DATA     = 2'd0,
    REG_STATUS   = 2'd1,
    REG_OVERFLOW = 2'd2,
    REG_SPARE    = 2'd3
  } reg_idx_t;

  // Address decode: the four registers sit at BASE_ADDR..BASE_ADDR+3.
  logic [CPU_WIDTH-1:0] offset;
  reg_idx_t             reg_idx;
  logic                 data_wr;
  logic                 ovf_clr;

  assign offset  = io_addr - BASE_ADDR;
  assign io_sel  = (offset[CPU_WIDTH-1:2] == '0);
  assign reg_idx = reg_idx_t'(offset[1:0]);
  assign data_wr = io_write && io_sel && (reg_idx == REG_DATA);
  assign ovf_clr = io_write && io_sel && (reg_idx == REG_OVERFLOW);

  // The upper write-data byte carries no meaning for this block.
  logic unused_wr_hi;
  assign unused_wr_hi = ^io_wr_data[CPU_WIDTH-1:8];

  // FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             push;
  logic             drop;
  logic             pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign push  = data_wr && !full;
  assign drop  = data_wr && full;

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values of its peers.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is deliberately not reset; count and pointers alone define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= io_wr_data[7:0];
  end

  // Dropped-byte counter, saturating so software can tell "many" from "wrapped".
  logic [7:0] ovf;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf <= '0;
    end else if (ovf_clr) begin
      ovf <= '0;
    end else if (drop && (ovf != 8'hFF)) begin
      ovf <= ovf + 1'b1;
    end
  end

  // Serializer
  state_t            state, state_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic              tx_nxt;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    shreg_nxt = shreg;
    bcnt_nxt  = bcnt;
    bit_nxt   = bit_idx;
    pop       = 1'b0;

    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          bcnt_nxt  = BCNT_RELOAD;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (bcnt == '0) begin
          bit_nxt   = '0;
          bcnt_nxt  = BCNT_RELOAD;
          state_nxt = S_DATA;
        end else begin
          bcnt_nxt = bcnt - 1'b1;
        end
      end
      S_DATA: begin
        if (bcnt == '0) begin
          shreg_nxt = {1'b0, shreg[7:1]};
          bcnt_nxt  = BCNT_RELOAD;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
          else                 bit_nxt   = bit_idx + 1'b1;
        end else begin
          bcnt_nxt = bcnt - 1'b1;
        end
      end
      S_STOP: begin
        if (bcnt == '0) state_nxt = S_IDLE;
        else            bcnt_nxt  = bcnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    // tx is registered from the next state so the line never glitches.
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
      tx_active <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bcnt      <= bcnt_nxt;
      bit_idx   <= bit_nxt;
      tx        <= tx_nxt;
      tx_active <= (state_nxt != S_IDLE);
    end
  end

  // Read mux: zero when not selected so peripherals can be OR-ed together.
  always_comb begin
    io_rd_data = '0;
    if (io_sel) begin
      case (reg_idx)
        REG_STATUS:   io_rd_data = CPU_WIDTH'({tx_active, empty, full});
        REG_OVERFLOW: io_rd_data = CPU_WIDTH'(ovf);
        default:      io_rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: a scoreboard of expected bytes is filled on
// writes and drained by a serial-line monitor that captures whole frames.
module tb_io_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;
  localparam int GAP   = FRAME + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_write = 1'b0;
  logic [15:0] io_addr = '0;
  logic [15:0] io_wr_data = '0;
  logic [15:0] io_rd_data;
  logic        io_sel;
  logic        tx;
  logic        tx_active;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  int         starts[$];
  int         cyc = 0;
  bit         mon_en = 1'b1;
  int         mon_n = 0;
  logic [FRAME-1:0] mon_fr = '0;

  always #50 clock = ~clock;

  io_uart_tx #(
    .CPU_WIDTH   (16),
    .BASE_ADDR   (16'h4000),
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .io_addr   (io_addr),
    .io_write  (io_write),
    .io_wr_data(io_wr_data),
    .io_rd_data(io_rd_data),
    .io_sel    (io_sel),
    .tx        (tx),
    .tx_active (tx_active)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line samples of one frame, one sample per clock, start bit first.
  function automatic logic [FRAME-1:0] exp_frame(input logic [7:0] b);
    logic [FRAME-1:0] f;
    f = '0;
    for (int s = 0; s < FRAME; s++) begin
      if (s / C == 0)      f[s] = 1'b0;
      else if (s / C == 9) f[s] = 1'b1;
      else                 f[s] = b[s / C - 1];
    end
    return f;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_addr    = a;
    io_wr_data = d;
    io_write   = 1'b1;
    tick();
    io_write   = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] a, input logic [15:0] exp,
                        input logic exp_sel);
    io_write = 1'b0;
    io_addr  = a;
    #1;
    check({tag, "_data"}, io_rd_data, exp);
    check({tag, "_sel"}, io_sel, exp_sel);
  endtask

  // Serial monitor: captures FRAME samples from each start bit on the falling edge.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        mon_n = 0;
      end else if (mon_n == 0) begin
        if (tx === 1'b0) begin
          mon_fr[0] = tx;
          mon_n     = 1;
          starts.push_back(cyc);
        end
      end else begin
        mon_fr[mon_n] = tx;
        mon_n++;
        if (mon_n == FRAME) begin
          mon_n = 0;
          if (mon_en) begin
            check("frame_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("frame_bits", mon_fr, exp_frame(e));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int w;
    int s0;
    int t;

    // Reset state and address decode
    tick(3);
    reset = 1'b0;
    check("reset_tx", tx, 1'b1);
    check("reset_active", tx_active, 1'b0);
    chk_rd("status_reset", 16'h4001, 16'h0002, 1'b1);
    chk_rd("spare_reg", 16'h4003, 16'h0000, 1'b1);
    chk_rd("data_reg", 16'h4000, 16'h0000, 1'b1);
    chk_rd("unmapped_low", 16'h3000, 16'h0000, 1'b0);
    chk_rd("unmapped_above", 16'h4004, 16'h0000, 1'b0);
    tick();

    // Single frame 0x55; upper data byte ignored
    s0 = starts.size();
    wr(16'h4000, 16'h1255);
    sb.push_back(8'h55);
    w = cyc;
    tick(10);
    chk_rd("status_mid", 16'h4001, 16'h0006, 1'b1);
    check("active_mid", tx_active, 1'b1);
    tick(30);
    chk_rd("status_last", 16'h4001, 16'h0006, 1'b1);
    check("stop_bit", tx, 1'b1);
    tick();
    chk_rd("status_done", 16'h4001, 16'h0002, 1'b1);
    check("active_done", tx_active, 1'b0);
    check("one_frame", starts.size() - s0, 1);
    if (starts.size() > s0) check("start_latency", starts[s0] - w, 2);
    check("sb_empty_1", sb.size(), 0);

    // Ten back-to-back writes: one popped, eight queued, one dropped
    s0 = starts.size();
    for (int i = 1; i <= 10; i++) begin
      wr(16'h4000, 16'(i));
      if (i <= 9) sb.push_back(8'(i));
    end
    chk_rd("status_full", 16'h4001, 16'h0005, 1'b1);
    chk_rd("ovf_one", 16'h4002, 16'h0001, 1'b1);
    t = 0;
    while ((sb.size() != 0 || tx_active) && t < 2000) begin
      tick();
      t++;
    end
    check("drain_in_time", (t < 2000), 1'b1);
    check("nine_frames", starts.size() - s0, 9);
    for (int k = 1; k < 9; k++) begin
      if (s0 + k < starts.size()) check("frame_gap", starts[s0 + k] - starts[s0 + k - 1], GAP);
    end

    // Overflow clear, ignored status write, saturation
    wr(16'h4002, 16'h0000);
    chk_rd("ovf_cleared", 16'h4002, 16'h0000, 1'b1);
    wr(16'h4001, 16'hFFFF);
    chk_rd("status_wr_ignored", 16'h4001, 16'h0002, 1'b1);
    mon_en = 1'b0;
    for (int i = 0; i < 320; i++) wr(16'h4000, 16'h00EE);
    chk_rd("ovf_saturated", 16'h4002, 16'h00FF, 1'b1);
    chk_rd("status_sat", 16'h4001, 16'h0005, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_rd("ovf_after_reset", 16'h4002, 16'h0000, 1'b1);
    chk_rd("status_after_reset", 16'h4001, 16'h0002, 1'b1);
    sb.delete();
    mon_en = 1'b1;
    tick();

    // Reset during DATA bit 3 with three bytes queued
    for (int i = 0; i < 4; i++) wr(16'h4000, 16'(8'h31 + i));
    tick(16);
    check("mid_active", tx_active, 1'b1);
    check("mid_bit3", tx, 1'b0);
    chk_rd("mid_status", 16'h4001, 16'h0004, 1'b1);
    reset = 1'b1;
    tick();
    check("rst_tx", tx, 1'b1);
    check("rst_active", tx_active, 1'b0);
    chk_rd("rst_status", 16'h4001, 16'h0002, 1'b1);
    reset = 1'b0;
    s0 = starts.size();
    tick(200);
    check("no_frames_after_reset", starts.size() - s0, 0);
    check("idle_tx", tx, 1'b1);

    // Writes that must not push
    s0 = starts.size();
    io_addr  = 16'h4000;
    io_write = 1'b0;
    tick();
    wr(16'h0000, 16'h0077);
    wr(16'h8000, 16'h0077);
    wr(16'h4003, 16'h0077);
    tick(2);
    chk_rd("nopush_status", 16'h4001, 16'h0002, 1'b1);
    tick(60);
    check("nopush_frames", starts.size() - s0, 0);
    check("nopush_active", tx_active, 1'b0);
    chk_rd("spare_after_wr", 16'h4003, 16'h0000, 1'b1);
    check("sb_final", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
